// File: rtl/fp_adder_arbiter.sv
// Round-robin arbiter that time-shares one multi-cycle floating-point adder
// between NUM_REQ requesters, with a watchdog against a hung adder.
module fp_adder_arbiter #(
    parameter int EXP_LEN        = 8,
    parameter int MANTISSA_LEN   = 23,
    parameter int NUM_REQ        = 4,
    parameter int TIMEOUT_CYCLES = 64,
    localparam int W             = EXP_LEN + MANTISSA_LEN + 1,
    localparam int IDW           = (NUM_REQ > 2) ? $clog2(NUM_REQ) : 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [NUM_REQ-1:0]   req_valid,
    input  logic [NUM_REQ*W-1:0] req_a,
    input  logic [NUM_REQ*W-1:0] req_b,
    output logic [NUM_REQ-1:0]   req_ready,
    output logic [NUM_REQ-1:0]   resp_valid,
    output logic [W-1:0]         resp_sum,
    output logic                 resp_err,
    output logic [W-1:0]         add_a,
    output logic [W-1:0]         add_b,
    output logic                 add_start,
    input  logic [W-1:0]         add_sum,
    input  logic                 add_done,
    output logic                 busy,
    output logic [IDW-1:0]       grant_id
);

    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT_LO,
        S_WAIT_HI,
        S_RESP
    } state_t;

    state_t           state;
    logic [IDW-1:0]   rr_ptr;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_next;
    logic             found;
    logic [IDW-1:0]   winner;
    logic             grant_now;
    logic             timed_out;
    logic [NUM_REQ-1:0] owner_onehot;
    logic [NUM_REQ-1:0] winner_onehot;

    // Search starts at rr_ptr and wraps, so the last winner drops to lowest priority.
    always_comb begin
        found  = 1'b0;
        winner = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (!found && req_valid[(int'(rr_ptr) + k) % NUM_REQ]) begin
                found  = 1'b1;
                winner = IDW'((int'(rr_ptr) + k) % NUM_REQ);
            end
        end
    end

    // The adder has no reset, so never issue while it may still be busy.
    assign grant_now     = (state == S_IDLE) && add_done && found;
    assign winner_onehot = {{(NUM_REQ-1){1'b0}}, 1'b1} << winner;
    assign owner_onehot  = {{(NUM_REQ-1){1'b0}}, 1'b1} << grant_id;
    assign req_ready     = grant_now ? winner_onehot : '0;

    assign timed_out = (cnt >= CNT_W'(TIMEOUT_CYCLES - 1));
    assign cnt_next  = (cnt == CNT_W'(TIMEOUT_CYCLES)) ? cnt : cnt + 1'b1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= S_IDLE;
            rr_ptr     <= '0;
            cnt        <= '0;
            add_start  <= 1'b0;
            busy       <= 1'b0;
            resp_valid <= '0;
            resp_err   <= 1'b0;
            resp_sum   <= '0;
            add_a      <= '0;
            add_b      <= '0;
            grant_id   <= '0;
        end else begin
            add_start  <= 1'b0;
            resp_valid <= '0;
            case (state)
                S_IDLE: begin
                    if (grant_now) begin
                        add_a     <= req_a[int'(winner)*W +: W];
                        add_b     <= req_b[int'(winner)*W +: W];
                        grant_id  <= winner;
                        rr_ptr    <= IDW'((int'(winner) + 1) % NUM_REQ);
                        add_start <= 1'b1;
                        busy      <= 1'b1;
                        state     <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    cnt   <= '0;
                    state <= S_WAIT_LO;
                end
                S_WAIT_LO: begin
                    cnt <= cnt_next;
                    if (!add_done) begin
                        state <= S_WAIT_HI;
                    end else if (timed_out) begin
                        resp_sum   <= '0;
                        resp_err   <= 1'b1;
                        resp_valid <= owner_onehot;
                        state      <= S_RESP;
                    end
                end
                S_WAIT_HI: begin
                    cnt <= cnt_next;
                    if (add_done) begin
                        resp_sum   <= add_sum;
                        resp_err   <= 1'b0;
                        resp_valid <= owner_onehot;
                        state      <= S_RESP;
                    end else if (timed_out) begin
                        resp_sum   <= '0;
                        resp_err   <= 1'b1;
                        resp_valid <= owner_onehot;
                        state      <= S_RESP;
                    end
                end
                S_RESP: begin
                    busy  <= 1'b0;
                    state <= S_IDLE;
                end
                default: begin
                    busy  <= 1'b0;
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: doc/fp_adder_arbiter.md
Name: fp_adder_arbiter

Overview:
- Shares one multi-cycle float_point_adder instance between NUM_REQ requesters using round-robin arbitration.
- Latches the winning requester's operands and drives the adder's start/operand inputs.
- Tracks the adder's busy/done handshake and returns the sum to the granted requester only.
- Includes a watchdog so a hung adder cannot stall every requester.

Parameters:
- EXP_LEN, 8, exponent width of the float format
- MANTISSA_LEN, 23, mantissa width; W = EXP_LEN+MANTISSA_LEN+1
- NUM_REQ, 4, number of requesters (2..16); IDW = max(1, clog2(NUM_REQ))
- TIMEOUT_CYCLES, 64, maximum wait for adder completion before an error response

Ports:
- clk  in  1  clock; all logic on posedge
- rst_n  in  1  asynchronous active-low reset
- req_valid  in  NUM_REQ  request pending, one bit per requester
- req_a  in  NUM_REQ*W  operand A; slot i at [i*W +: W]
- req_b  in  NUM_REQ*W  operand B, same packing
- req_ready  out  NUM_REQ  one-cycle accept pulse to the granted requester
- resp_valid  out  NUM_REQ  one-cycle result pulse to the owning requester
- resp_sum  out  W  result, valid while any resp_valid bit is high
- resp_err  out  1  timeout flag, qualified by resp_valid
- add_a  out  W  to adder a
- add_b  out  W  to adder b
- add_start  out  1  to adder inp_data_ready
- add_sum  in  W  from adder sum
- add_done  in  1  from adder sum_ready; high when idle or finished
- busy  out  1  high in any state other than IDLE
- grant_id  out  IDW  index of the current owner, valid while busy

Behaviour:
- Reset (async, rst_n=0):
  - State IDLE, rr_ptr=0, timeout counter=0.
  - req_ready, resp_valid, resp_err, add_start, busy all 0; resp_sum, add_a, add_b, grant_id all 0.
- Requester rule: once req_valid[i] is raised, req_a/req_b slot i must stay stable and req_valid[i] must stay high until req_ready[i] pulses. Behaviour is undefined if a requester withdraws early.
- FSM: IDLE -> ISSUE -> WAIT_LO -> WAIT_HI -> RESP -> IDLE.
- IDLE:
  - A grant is allowed only when add_done=1. This guards against an adder that is still mid-operation after a reset, since the adder itself has no reset.
  - Winner g = first set bit of req_valid searching from rr_ptr upward, wrapping modulo NUM_REQ.
  - Same cycle: req_ready[g]=1 (combinational).
  - Registered on that edge: add_a/add_b <= slot g operands, grant_id <= g, rr_ptr <= (g+1) mod NUM_REQ, next state ISSUE.
  - No valid request: stay in IDLE.
- ISSUE: add_start=1 for exactly one cycle; counter cleared; next state WAIT_LO.
- WAIT_LO:
  - Waits for add_done=0, which means the adder accepted the start; then goes to WAIT_HI.
  - add_done stays 1 for TIMEOUT_CYCLES cycles: go to RESP with the error flag set.
- WAIT_HI:
  - On add_done=1: capture resp_sum <= add_sum, clear the error flag, go to RESP.
  - Counter reaches TIMEOUT_CYCLES: resp_sum <= 0, error flag set, go to RESP.
- Counter: increments every cycle in WAIT_LO/WAIT_HI, saturates, is cleared in ISSUE, and spans both wait states.
- RESP:
  - resp_valid[grant_id]=1 and resp_err=error flag, for one cycle; then IDLE.
  - resp_sum holds its value until the next capture.
- Throughput: at most one operation in flight.
- Latency: accept to resp_valid = 3 + adder latency cycles. The new arbitration decision is taken in the IDLE cycle that follows RESP.
- Fairness:
  - A requester that is continuously valid waits at most NUM_REQ-1 other grants.
  - The winner of simultaneous requests is decided purely by rr_ptr.
- A request arriving while busy is held off (req_ready=0) and is not lost.
- Reset asserted mid-operation:
  - The in-flight result is discarded and no resp_valid is generated.
  - After release, the IDLE add_done gate waits for the adder to finish before issuing again.
- add_a/add_b hold the latched operands for the whole operation; they change only on a grant.

Test Plan:
- Single request: req_valid=4'b0001, a=0x3F800000 (1.0), b=0x40000000 (2.0), bench adder with 6-cycle latency -> req_ready[0] pulses in cycle 0, add_start in cycle 1, resp_valid=4'b0001 with resp_sum=0x40400000 and resp_err=0 at cycle 3+6, exactly one pulse.
- All four requesters valid from reset, each with distinct operands -> grant order 0,1,2,3,0; every resp_valid bit matches its requester and carries its own sum; no overlapping operations.
- rr_ptr=2, then req_valid=4'b0011 -> grant 0, not 1; next grant is 1.
- Bench adder never raises add_done after the drop -> resp_err=1, resp_sum=0, resp_valid pulses TIMEOUT_CYCLES after entry to WAIT_LO (±1), arbiter returns to IDLE and serves the next request.
- rst_n pulsed low during WAIT_HI while the bench adder is still running -> all outputs return to their reset values asynchronously, no resp_valid follows; a pending request is granted only after add_done=1.
- Bench adder keeps add_done=1 (never accepts start) -> timeout error response from WAIT_LO; busy deasserts afterwards.
